// File: rtl/synth_pkg.sv
// synth_pkg: definitions shared by the oscillator bank.
//   wave_mode_e      - per-channel waveform select (cfg word 2i, bits [15:14])
//   CFG_* params     - fixed cfg field positions; the parameter-dependent
//                      oct/mantissa positions are derived in the top module
//   frame_len()      - slots per frame: one per channel plus the mix slot
package synth_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_OFF    = 2'd3
  } wave_mode_e;

  localparam int CFG_MODE_HI    = 15;
  localparam int CFG_MODE_LO    = 14;
  localparam int CFG_SWEEP_DOWN = 7;
  localparam int CFG_VOL_HI     = 10;
  localparam int CFG_VOL_LO     = 8;

  function automatic int frame_len(input int num_oscs);
    return num_oscs + 1;
  endfunction

endpackage

// File: rtl/osc_bank_mixer_if.sv
// osc_bank_mixer_if: cfg write bus and mix sample output of the oscillator bank.
//   cfg_be/cfg_addr/cfg_wdata - byte-enabled word write, always accepted
//   mix_out                   - signed mix sample, updated once per frame
//   sample_valid              - one-cycle pulse when mix_out updates
// master = configuration front end / sample consumer, slave = osc_bank_mixer.
interface osc_bank_mixer_if #(
  parameter int NUM_OSCS  = 4,
  parameter int WAVE_BITS = 4
);
  localparam int AW = $clog2(2*NUM_OSCS);
  localparam int MW = WAVE_BITS + $clog2(NUM_OSCS);

  logic [1:0]           cfg_be;
  logic [AW-1:0]        cfg_addr;
  logic [15:0]          cfg_wdata;
  logic signed [MW-1:0] mix_out;
  logic                 sample_valid;

  modport master (output cfg_be, cfg_addr, cfg_wdata, input mix_out, sample_valid);
  modport slave  (input cfg_be, cfg_addr, cfg_wdata, output mix_out, sample_valid);
endinterface

// File: rtl/tm_counter.sv
// tm_counter: time-multiplexed down-counter. The counter state lives in the
// caller's per-channel array; this block only computes the next value.
//   en       - counter is clocked in this slot
//   cnt      - current state of the serviced channel
//   reload   - value loaded when the counter expires
//   trig     - counter was at zero while enabled
//   cnt_next - state to write back
module tm_counter #(
  parameter int W = 10
) (
  input  logic         en,
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] reload,
  output logic         trig,
  output logic [W-1:0] cnt_next
);
  always_comb begin
    trig     = en && (cnt == '0);
    cnt_next = cnt;
    if (en) cnt_next = (cnt == '0) ? reload : cnt - 1'b1;
  end
endmodule

// File: rtl/osc_bank_mixer.sv
// osc_bank_mixer: NUM_OSCS oscillators sharing one datapath. Slot i of each
// frame services channel i (phase/sweep counters, wave sample into the
// accumulator); the final slot publishes the mix and clears the accumulator.
//   clk, reset - clock, asynchronous active-high reset
//   bus        - cfg write port in, mix_out/sample_valid out
module osc_bank_mixer
  import synth_pkg::*;
#(
  parameter int NUM_OSCS                 = 4,
  parameter int OCT_BITS                 = 4,
  parameter int PERIOD_BITS              = 10,
  parameter int WAVE_BITS                = 4,
  parameter int DIVIDER_BITS             = 16,
  parameter int SWEEP_PERIOD_BITS        = 4,
  parameter int LOG2_SWEEP_UPDATE_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  osc_bank_mixer_if.slave bus
);
  localparam int CW   = $clog2(NUM_OSCS);
  localparam int SLW  = $clog2(frame_len(NUM_OSCS));
  localparam int AW   = CW + 1;
  localparam int MW   = WAVE_BITS + CW;
  localparam int FW   = PERIOD_BITS + OCT_BITS - 1;  // {oct, mant} field
  localparam int EN_W = (1 << OCT_BITS) + LOG2_SWEEP_UPDATE_PERIOD;
  localparam int IW   = $clog2(EN_W);
  localparam logic [OCT_BITS-1:0] OCT_OFF = '1;

  logic [15:0]             cfg   [2*NUM_OSCS];
  logic [WAVE_BITS-1:0]    phase [NUM_OSCS];
  logic [PERIOD_BITS-1:0]  pcnt  [NUM_OSCS];
  logic [SWEEP_PERIOD_BITS-1:0] scnt [NUM_OSCS];
  logic [SLW-1:0]          slot;
  logic [DIVIDER_BITS-1:0] div;
  logic [MW-1:0]           acc, mix_q;
  logic                    valid_q;

  logic                    is_ch;
  logic [CW-1:0]           ch;
  logic [AW-1:0]           wa;
  logic [15:0]             w0, w1;
  wave_mode_e              mode;
  logic [OCT_BITS-1:0]     oct, soct;
  logic [PERIOD_BITS-2:0]  mant;
  logic [SWEEP_PERIOD_BITS-2:0] smant;
  logic [2:0]              vol;
  logic                    sdown;
  logic [DIVIDER_BITS-1:0] rise;
  logic [EN_W-1:0]         en_vec;
  logic [IW-1:0]           s_idx;
  logic                    p_en, s_en;
  logic [PERIOD_BITS-1:0]  p_reload;
  logic [SWEEP_PERIOD_BITS-1:0] s_reload;
  logic                    p_trig, s_trig;
  logic [PERIOD_BITS-1:0]  p_next;
  logic [SWEEP_PERIOD_BITS-1:0] s_next;
  logic [WAVE_BITS-1:0]    wv;
  logic signed [WAVE_BITS-1:0] sv;
  logic [MW-1:0]           sv_ext;
  logic [FW-1:0]           field, field_nx;
  logic                    sweep_upd;
  logic                    unused_bits;

  assign is_ch = (slot != SLW'(NUM_OSCS));
  assign ch    = is_ch ? CW'(slot) : '0;
  assign wa    = {ch, 1'b0};
  assign w0    = cfg[wa];
  assign w1    = cfg[wa | AW'(1)];
  assign unused_bits = ^{w0, w1};

  always_comb begin
    mode  = wave_mode_e'(w0[CFG_MODE_HI:CFG_MODE_LO]);
    oct   = w0[FW-1 -: OCT_BITS];
    mant  = w0[PERIOD_BITS-2:0];
    field = w0[FW-1:0];
    soct  = w1[SWEEP_PERIOD_BITS+OCT_BITS-2 -: OCT_BITS];
    smant = w1[SWEEP_PERIOD_BITS-2:0];
    sdown = w1[CFG_SWEEP_DOWN];
    vol   = w1[CFG_VOL_HI:CFG_VOL_LO];

    // Lowest set bit of the divider = the bit that rose when it last
    // incremented; en[k] follows divider bit k-1, en[0] is always on.
    rise   = div & (~div + 1'b1);
    en_vec = EN_W'({rise, 1'b1});
    s_idx  = IW'(soct) + IW'(LOG2_SWEEP_UPDATE_PERIOD);
    p_en   = is_ch && (oct  != OCT_OFF) && en_vec[oct];
    s_en   = is_ch && (soct != OCT_OFF) && en_vec[s_idx];

    p_reload = {1'b1, mant} - 1'b1;
    s_reload = {1'b1, smant};
  end

  tm_counter #(.W(PERIOD_BITS)) u_phase_cnt (
    .en(p_en), .cnt(pcnt[ch]), .reload(p_reload), .trig(p_trig), .cnt_next(p_next)
  );

  tm_counter #(.W(SWEEP_PERIOD_BITS)) u_sweep_cnt (
    .en(s_en), .cnt(scnt[ch]), .reload(s_reload), .trig(s_trig), .cnt_next(s_next)
  );

  // Wave shaping on the channel's phase before this slot's update.
  always_comb begin
    case (mode)
      WAVE_SAW:    wv = phase[ch];
      WAVE_SQUARE: wv = {WAVE_BITS{phase[ch][WAVE_BITS-1]}};
      WAVE_TRI:    wv = {phase[ch][WAVE_BITS-2:0] ^ {(WAVE_BITS-1){phase[ch][WAVE_BITS-1]}}, 1'b0};
      default:     wv = {1'b1, {(WAVE_BITS-1){1'b0}}};
    endcase
    sv     = $signed({~wv[WAVE_BITS-1], wv[WAVE_BITS-2:0]}) >>> vol;
    sv_ext = {{(MW-WAVE_BITS){sv[WAVE_BITS-1]}}, sv};
  end

  // Saturating sweep of {oct, mant}; any same-cycle write to the word wins.
  always_comb begin
    field_nx  = sdown ? field - 1'b1 : field + 1'b1;
    sweep_upd = s_trig && !(sdown ? (field == '0) : (&field)) &&
                !((|bus.cfg_be) && (bus.cfg_addr == wa));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2*NUM_OSCS; i++) cfg[i] <= '0;
      for (int i = 0; i < NUM_OSCS; i++) begin
        phase[i] <= '0;
        pcnt[i]  <= '0;
        scnt[i]  <= '0;
      end
      slot    <= '0;
      div     <= '0;
      acc     <= '0;
      mix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (is_ch) begin
        pcnt[ch] <= p_next;
        scnt[ch] <= s_next;
        if (p_trig) phase[ch] <= phase[ch] + 1'b1;
        acc <= acc + sv_ext;
        if (sweep_upd) cfg[wa][FW-1:0] <= field_nx;
        slot <= slot + 1'b1;
      end else begin
        mix_q   <= acc;
        acc     <= '0;
        valid_q <= 1'b1;
        div     <= div + 1'b1;
        slot    <= '0;
      end
      if (bus.cfg_be[0]) cfg[bus.cfg_addr][7:0]  <= bus.cfg_wdata[7:0];
      if (bus.cfg_be[1]) cfg[bus.cfg_addr][15:8] <= bus.cfg_wdata[15:8];
    end
  end

  assign bus.mix_out      = mix_q;
  assign bus.sample_valid = valid_q;

endmodule

// File: tb/tb_osc_bank_mixer.sv
// tb_osc_bank_mixer: random and directed cfg traffic against a frame-level
// behavioural model; mix_out and sample_valid are compared every cycle.
module tb_osc_bank_mixer;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int AW = $clog2(2*N);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  osc_bank_mixer_if #(.NUM_OSCS(N), .WAVE_BITS(W)) bus ();

  osc_bank_mixer #(
    .NUM_OSCS(N), .OCT_BITS(4), .PERIOD_BITS(10), .WAVE_BITS(W),
    .DIVIDER_BITS(16), .SWEEP_PERIOD_BITS(4), .LOG2_SWEEP_UPDATE_PERIOD(2)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int m_cfg [2*N];
  int m_phase [N];
  int m_pcnt [N];
  int m_scnt [N];
  int m_acc, m_mix, m_valid, m_slot, m_frame;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Octave k is active in frame f when bit k-1 of the frame count just rose.
  function automatic bit oct_en(input int k, input int frame);
    int d;
    d = frame % 65536;
    if (k == 0) return 1'b1;
    if (k > 16) return 1'b0;
    return (d % (1 << k)) == (1 << (k - 1));
  endfunction

  function automatic int wave_val(input int mode, input int p, input int vol);
    int m, v;
    m = (p >> 3) & 1;
    case (mode)
      0: v = p - 8;
      1: v = m ? 7 : -8;
      2: v = 2 * ((p & 7) ^ (m ? 7 : 0)) - 8;
      default: v = 0;
    endcase
    return v >>> vol;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2*N; i++) m_cfg[i] = 0;
    for (int i = 0; i < N; i++) begin
      m_phase[i] = 0; m_pcnt[i] = 0; m_scnt[i] = 0;
    end
    m_acc = 0; m_mix = 0; m_valid = 0; m_slot = 0; m_frame = 0;
  endtask

  task automatic model_step(input logic [1:0] be, input int addr, input int data);
    int i, w0, w1, oct, mant, soct, smant, down, vol, field;
    bit fire;
    m_valid = 0;
    if (m_slot < N) begin
      i = m_slot; w0 = m_cfg[2*i]; w1 = m_cfg[2*i+1];
      oct = (w0 >> 9) & 15; mant = w0 & 511;
      soct = (w1 >> 3) & 15; smant = w1 & 7; down = (w1 >> 7) & 1; vol = (w1 >> 8) & 7;
      m_acc += wave_val((w0 >> 14) & 3, m_phase[i], vol);
      if (oct != 15 && oct_en(oct, m_frame)) begin
        if (m_pcnt[i] == 0) begin
          m_pcnt[i] = 512 + mant - 1;
          m_phase[i] = (m_phase[i] + 1) % 16;
        end else m_pcnt[i]--;
      end
      fire = 0;
      if (soct != 15 && oct_en(soct + 2, m_frame)) begin
        if (m_scnt[i] == 0) begin m_scnt[i] = 8 + smant; fire = 1; end
        else m_scnt[i]--;
      end
      if (fire && !(be != 0 && addr == 2*i)) begin
        field = w0 & 8191;
        if (down && field > 0) field--;
        else if (!down && field < 8191) field++;
        m_cfg[2*i] = (w0 & ~8191) | field;
      end
      m_slot++;
    end else begin
      m_mix = m_acc; m_acc = 0; m_valid = 1; m_frame++; m_slot = 0;
    end
    if (be[0]) m_cfg[addr] = (m_cfg[addr] & 'hFF00) | (data & 'h00FF);
    if (be[1]) m_cfg[addr] = (m_cfg[addr] & 'h00FF) | (data & 'hFF00);
  endtask

  function automatic bit model_fire_next(input int c);
    int soct;
    soct = (m_cfg[2*c+1] >> 3) & 15;
    return m_slot == c && soct != 15 && oct_en(soct + 2, m_frame) && m_scnt[c] == 0;
  endfunction

  task automatic tick(input logic [1:0] be, input int addr, input int data);
    @(negedge clk);
    bus.cfg_be = be; bus.cfg_addr = AW'(addr); bus.cfg_wdata = 16'(data);
    @(posedge clk);
    model_step(be, addr, data);
    #1;
    chk("sample_valid", bus.sample_valid, m_valid);
    chk("mix_out", bus.mix_out, m_mix);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(2'b00, 0, 0);
  endtask

  function automatic int rand_w0();
    int oct;
    oct = ($urandom_range(0, 4) == 0) ? 15 : $urandom_range(0, 1);
    return ($urandom_range(0, 3) << 14) | ($urandom_range(0, 1) << 13) |
           (oct << 9) | $urandom_range(0, 63);
  endfunction

  function automatic int rand_w1();
    int soct;
    soct = ($urandom_range(0, 1) == 0) ? 15 : $urandom_range(0, 1);
    return ($urandom_range(0, 31) << 11) | ($urandom_range(0, 7) << 8) |
           ($urandom_range(0, 1) << 7) | (soct << 3) | $urandom_range(0, 7);
  endfunction

  initial begin
    int k;
    bit found;
    bus.cfg_be = 2'b00; bus.cfg_addr = '0; bus.cfg_wdata = '0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_mix_out", bus.mix_out, 0);
    chk("reset_sample_valid", bus.sample_valid, 0);
    reset = 1'b0;

    // all-zero cfg: saw channels with sweep up at octave 0
    idle(3000);

    // random configs with sparse random writes
    for (int seg = 0; seg < 5; seg++) begin
      for (int a = 0; a < 2*N; a++)
        tick(2'b11, a, (a % 2 == 0) ? rand_w0() : rand_w1());
      for (int c = 0; c < 5000; c++) begin
        if ($urandom_range(0, 149) == 0)
          tick(2'($urandom_range(1, 3)), $urandom_range(0, 2*N-1), $urandom_range(0, 65535));
        else
          tick(2'b00, 0, 0);
      end
    end

    // sweep saturation: up at all-ones, then down from 1 to 0
    for (int c = 1; c < N; c++) tick(2'b11, 2*c, 3 << 14);
    tick(2'b11, 0, 'h1FFF);
    tick(2'b11, 1, 'h0000);
    idle(600);
    tick(2'b11, 0, 'h0001);
    tick(2'b11, 1, 'h0080);
    idle(1500);

    // ch1 saw with volume shift 2, sweep off
    tick(2'b11, 2, 'h0000);
    tick(2'b11, 3, (2 << 8) | (15 << 3));
    idle(500);

    // write collides with a ch0 sweep trigger
    tick(2'b11, 1, (1 << 3) | 7);
    tick(2'b11, 0, 'h01FF);
    found = 1'b0;
    for (int c = 0; c < 5000 && !found; c++) begin
      if (model_fire_next(0)) found = 1'b1;
      else tick(2'b00, 0, 0);
    end
    chk("collision_slot_found", found, 1);
    tick(2'b01, 0, 'h0000);
    idle(4000);

    // reset in slot 2 of a frame
    for (int a = 0; a < 2*N; a++) tick(2'b11, a, 0);
    idle(20);
    k = 0;
    while (m_slot != 2 && k < 10) begin tick(2'b00, 0, 0); k++; end
    chk("reach_slot2", m_slot, 2);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("midframe_reset_mix_out", bus.mix_out, 0);
    chk("midframe_reset_valid", bus.sample_valid, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    k = 0;
    found = 1'b0;
    while (!found && k < 10) begin
      tick(2'b00, 0, 0);
      k++;
      if (bus.sample_valid === 1'b1) found = 1'b1;
    end
    chk("first_valid_after_reset", k, N + 1);
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
